prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Serial program loader that drives the eight-bit computer's RAM programming interface from a UART-style 8N1 bit stream.
- Receives a sync byte followed by 16 program bytes. Writes each byte into RAM addresses 0..15 while asserting prog_mode, then releases the CPU to run.
- Sits between the board's serial pin and the computer top level's prog_mode/addr/data_in inputs.
- Runs on fastClk, not the divided CPU clock.

Parameters:
- CLKS_PER_BIT, 16, fastClk cycles per serial bit; must be >= 4.
- SYNC_BYTE, 8'hA5, byte that opens a load session.
- TIMEOUT_CYCLES, 65536, idle fastClk cycles allowed between bytes inside a session before abort.

Ports:
- fastClk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-low reset.
- rx  input  1  serial data, idle high, asynchronous to fastClk.
- prog_mode  output  1  high while a session is in progress; drives the computer's prog_mode.
- prog_addr  output  4  RAM write address.
- prog_data  output  8  RAM write data.
- prog_we  output  1  one-cycle write strobe; prog_addr/prog_data valid when high.
- busy  output  1  high from first start bit detected until receiver returns to idle.
- load_done  output  1  one-cycle pulse after the 16th byte is written.
- load_err  output  1  one-cycle pulse on session abort (timeout, framing error in session, checksum fail).
- frame_err  output  1  one-cycle pulse when a stop bit samples low.

Behaviour:
- Reset (rst low at a rising edge): every output is 0 on the following edge, both FSMs return to IDLE, all counters clear. This holds mid-session too; prog_mode drops with no load_done or load_err.
- rx passes through a 2-flop synchronizer before use; the 2-cycle latency is not compensated.
- Receiver FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: a synchronized rx low moves to RX_START, bit counter cleared.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then resample. Low goes to RX_DATA; high is a glitch and returns to RX_IDLE with no flags.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - RX_STOP: sample after CLKS_PER_BIT cycles. High gives a 1-cycle byte_valid (internal) with the byte. Low gives a frame_err pulse and discards the byte. Both return to RX_IDLE.
- Loader FSM states: L_IDLE, L_RECV, L_WRITE, L_DONE.
  - L_IDLE: prog_mode=0. A valid byte equal to SYNC_BYTE moves to L_RECV, sets addr counter to 0 and prog_mode to 1. Any other byte is ignored.
  - L_RECV: on a valid byte, latch it into prog_data, drive prog_addr=addr counter, go to L_WRITE. The timeout counter resets on every valid byte. If it reaches TIMEOUT_CYCLES-1, pulse load_err, go to L_IDLE, drop prog_mode.
  - L_WRITE: prog_we=1 for exactly one cycle. If addr counter = 15, go to L_DONE. Otherwise increment and go to L_RECV.
  - L_DONE: pulse load_done for one cycle, drop prog_mode, go to L_IDLE.
- A frame_err while in L_RECV aborts the session: load_err pulses the same cycle, then L_IDLE.
- A SYNC_BYTE value received inside a session is ordinary data, not a restart.
- prog_addr/prog_data hold their last values outside write cycles.
- The addr counter is 4-bit and never wraps; termination is by state.
- Latency: prog_we is asserted 1 cycle after byte_valid. load_done is asserted 2 cycles after the 16th byte_valid.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- When defined:
  - After byte 15 is written, L_DONE is replaced by L_CHECK, which waits for one more byte.
  - If that byte equals the 8-bit modulo-256 sum of the 16 data bytes: load_done pulses, then idle.
  - If it does not match: load_err pulses, prog_mode drops, and RAM contents are left as written.
  - Timeout applies in L_CHECK.
- When not defined: no accumulator, no L_CHECK state, behaviour exactly as above.

Test Plan:
- CLKS_PER_BIT=4. Send A5 then bytes 00..0F. Required: 16 prog_we pulses with prog_addr 0..15 and prog_data 00..0F; prog_mode high from the cycle after the A5 stop-bit sample until load_done; load_done pulses once; load_err stays 0.
- In L_IDLE, send 3C then 11. Required: no prog_mode, no prog_we, no flags.
- Send A5, 5 data bytes, then a byte with stop bit low. Required: frame_err and load_err pulse together, prog_mode drops, and exactly 5 prog_we pulses occur.
- TIMEOUT_CYCLES=64. Send A5, 2 bytes, then hold rx high 64 cycles. Required: load_err pulses on the 64th idle cycle and prog_mode drops.
- Send A5 and 8 bytes, then assert rst low for 1 cycle mid-byte. Required: all outputs 0 on the next edge. A fresh A5 plus 16 bytes then completes normally from addr 0.
- With PROG_LOADER_CHECKSUM_EN: send A5, 16 bytes 01, then 10. Required: load_done. Repeat with final byte 11. Required: load_err and no load_done.

Source files
------------

// File: rtl/prog_loader.sv
// 8N1 serial program loader: a sync byte opens a session, the next 16 bytes are written to RAM 0..15.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte before load_done.
module prog_loader #(
    parameter int         CLKS_PER_BIT   = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65536
) (
    input  logic       fastClk,
    input  logic       rst,
    input  logic       rx,
    output logic       prog_mode,
    output logic [3:0] prog_addr,
    output logic [7:0] prog_data,
    output logic       prog_we,
    output logic       busy,
    output logic       load_done,
    output logic       load_err,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {L_IDLE, L_RECV, L_WRITE, L_DONE, L_CHECK} ld_state_t;
`else
    typedef enum logic [2:0] {L_IDLE, L_RECV, L_WRITE, L_DONE} ld_state_t;
`endif

    logic          rx_meta_q, rx_sync_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, rx_byte_q, rx_byte_d;
    logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d, busy_q, busy_d;

    ld_state_t     ld_state_q, ld_state_d;
    logic [3:0]    addr_q, addr_d, prog_addr_q, prog_addr_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [7:0]    prog_data_q, prog_data_d;
    logic          prog_mode_q, prog_mode_d, prog_we_q, prog_we_d;
    logic          load_done_q, load_done_d, load_err_q, load_err_d;
    logic          in_wait;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
                rx_state_d = RX_START;
                clk_cnt_d  = '0;
                bit_cnt_d  = '0;
            end
            RX_START: if (clk_cnt_q == HALF_LAST) begin
                clk_cnt_d  = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
                clk_cnt_d = clk_cnt_q + CW'(1);
            end
            RX_DATA: if (clk_cnt_q == BIT_LAST) begin
                clk_cnt_d = '0;
                shift_d   = {rx_sync_q, shift_q[7:1]};
                if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                else                   bit_cnt_d  = bit_cnt_q + 3'd1;
            end else begin
                clk_cnt_d = clk_cnt_q + CW'(1);
            end
            RX_STOP: if (clk_cnt_q == BIT_LAST) begin
                rx_state_d = RX_IDLE;
                if (rx_sync_q) begin
                    byte_valid_d = 1'b1;
                    rx_byte_d    = shift_q;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                clk_cnt_d = clk_cnt_q + CW'(1);
            end
            default: rx_state_d = RX_IDLE;
        endcase
        busy_d = (rx_state_d != RX_IDLE);
    end

    always_comb begin
        ld_state_d  = ld_state_q;
        addr_d      = addr_q;
        prog_mode_d = prog_mode_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_we_d   = 1'b0;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        timer_inc   = timer_q + TW'(1);
        timer_d     = byte_valid_q ? '0 : timer_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        in_wait     = (ld_state_q == L_RECV) || (ld_state_q == L_CHECK);
`else
        in_wait     = (ld_state_q == L_RECV);
`endif
        unique case (ld_state_q)
            L_IDLE: if (byte_valid_q && rx_byte_q == SYNC_BYTE) begin
                ld_state_d  = L_RECV;
                addr_d      = '0;
                prog_mode_d = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d       = '0;
`endif
            end
            L_RECV: if (byte_valid_q) begin
                prog_data_d = rx_byte_q;
                prog_addr_d = addr_q;
                prog_we_d   = 1'b1;
                ld_state_d  = L_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d       = sum_q + rx_byte_q;
`endif
            end
            L_WRITE: if (addr_q == 4'd15) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                ld_state_d  = L_CHECK;
`else
                ld_state_d  = L_DONE;
                load_done_d = 1'b1;
`endif
            end else begin
                addr_d     = addr_q + 4'd1;
                ld_state_d = L_RECV;
            end
            L_DONE: begin
                prog_mode_d = 1'b0;
                ld_state_d  = L_IDLE;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            L_CHECK: if (byte_valid_q) begin
                if (rx_byte_q == sum_q) begin
                    load_done_d = 1'b1;
                    ld_state_d  = L_DONE;
                end else begin
                    load_err_d  = 1'b1;
                    prog_mode_d = 1'b0;
                    ld_state_d  = L_IDLE;
                end
            end
`endif
            default: ld_state_d = L_IDLE;
        endcase
        // Abort uses the receiver's next-state flag so load_err lines up with frame_err.
        if (in_wait && (frame_err_d || (!byte_valid_q && timer_inc == TIMEOUT_LAST))) begin
            load_err_d  = 1'b1;
            prog_mode_d = 1'b0;
            prog_we_d   = 1'b0;
            ld_state_d  = L_IDLE;
        end
        if (ld_state_d == L_IDLE) timer_d = '0;
    end

    always_ff @(posedge fastClk) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            ld_state_q   <= L_IDLE;
            addr_q       <= '0;
            timer_q      <= '0;
            prog_mode_q  <= 1'b0;
            prog_addr_q  <= '0;
            prog_data_q  <= '0;
            prog_we_q    <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            ld_state_q   <= ld_state_d;
            addr_q       <= addr_d;
            timer_q      <= timer_d;
            prog_mode_q  <= prog_mode_d;
            prog_addr_q  <= prog_addr_d;
            prog_data_q  <= prog_data_d;
            prog_we_q    <= prog_we_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign prog_mode = prog_mode_q;
    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign prog_we   = prog_we_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: the rx waveform and a per-cycle expectation timeline are planned up front
// from byte-level session rules, then the DUT is run and every output is compared each cycle.
module tb_prog_loader;
    localparam int C      = 4;
    localparam int H      = C / 2;
    localparam int T      = 64;
    localparam int N      = 5000;
    localparam int FRAME  = 10 * C;
    // start-bit first cycle -> cycle the received byte is complete (2 sync + 1 detect + half bit + 9 bits)
    localparam int RX_LAT = 3 + H + 9 * C;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int N_WE = 79, N_DONE = 3, N_ERR = 3;
`else
    localparam int N_WE = 47, N_DONE = 2, N_ERR = 2;
`endif

    logic       fastClk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       prog_mode, prog_we, busy, load_done, load_err, frame_err;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;

    prog_loader #(.CLKS_PER_BIT(C), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
        .fastClk(fastClk), .rst(rst), .rx(rx),
        .prog_mode(prog_mode), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_we(prog_we), .busy(busy), .load_done(load_done),
        .load_err(load_err), .frame_err(frame_err)
    );

    always #5 fastClk = ~fastClk;

    logic       rx_wave[N];
    logic       rst_wave[N];
    logic       e_mode[N], e_we[N], e_busy[N], e_done[N], e_err[N], e_ferr[N];
    logic [3:0] e_addr[N];
    logic [7:0] e_data[N];

    int pc, plan_len, cur, t1_first, t4_last;
    bit checking = 1'b0;
    bit sess;
    int cnt, last_v;
    logic [7:0] sum;
    int vectors = 0, miscompares = 0;
    int n_we = 0, n_done = 0, n_err = 0, n_ferr = 0, first_we = -1, model_we;
    int err_q[$];

    task automatic fill_mode(input int from, input logic v);
        for (int c = from; c < N; c++) e_mode[c] = v;
    endtask

    // Session model: reacts to whole bytes at the cycle they complete.
    task automatic model_timeout(input int now);
        if (sess && now >= last_v + T && last_v + T < N) begin
            e_err[last_v + T] = 1'b1;
            fill_mode(last_v + T, 1'b0);
            sess = 1'b0;
        end
    endtask

    task automatic model_byte(input int v, input logic [7:0] d, input bit ok);
        model_timeout(v);
        if (!ok) begin
            e_ferr[v] = 1'b1;
            if (sess) begin
                e_err[v] = 1'b1;
                fill_mode(v, 1'b0);
                sess = 1'b0;
            end
        end else if (!sess) begin
            if (d == SYNC) begin
                sess = 1'b1; cnt = 0; sum = 8'h00; last_v = v;
                fill_mode(v + 1, 1'b1);
            end
        end else if (cnt < 16) begin
            last_v = v;
            e_we[v + 1] = 1'b1;
            for (int c = v + 1; c < N; c++) begin
                e_addr[c] = 4'(cnt);
                e_data[c] = d;
            end
            sum = sum + d;
            cnt++;
`ifndef PROG_LOADER_CHECKSUM_EN
            if (cnt == 16) begin
                e_done[v + 2] = 1'b1;
                fill_mode(v + 3, 1'b0);
                sess = 1'b0;
            end
`endif
        end else begin
            if (d == sum) begin
                e_done[v + 1] = 1'b1;
                fill_mode(v + 2, 1'b0);
            end else begin
                e_err[v + 1] = 1'b1;
                fill_mode(v + 1, 1'b0);
            end
            sess = 1'b0;
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input bit ok, input int i);
        int b;
        b = i / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return ok ? 1'b1 : ((i % C) == C - 1);
    endfunction

    task automatic plan_frame(input logic [7:0] d, input bit ok);
        int s;
        s = pc;
        for (int i = 0; i < FRAME; i++) rx_wave[s + i] = frame_bit(d, ok, i);
        for (int c = s + 3; c < s + RX_LAT; c++) e_busy[c] = 1'b1;
        model_byte(s + RX_LAT, d, ok);
        pc += FRAME;
    endtask

    task automatic plan_cut_reset(input logic [7:0] d, input int k);
        int s, r;
        s = pc;
        r = s + k;
        for (int i = 0; i < k; i++) rx_wave[s + i] = frame_bit(d, 1'b1, i);
        for (int c = s + 3; c <= r; c++) e_busy[c] = 1'b1;
        rst_wave[r] = 1'b0;
        model_timeout(r);
        for (int c = r + 1; c < N; c++) begin
            e_mode[c] = 0; e_we[c] = 0; e_busy[c] = 0; e_done[c] = 0;
            e_err[c] = 0; e_ferr[c] = 0; e_addr[c] = '0; e_data[c] = '0;
        end
        sess = 1'b0;
        pc = r + 1;
    endtask

    task automatic plan_idle(input int n);
        pc += n;
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic do_check(input int c);
        logic [17:0] act, req;
        act = {prog_mode, prog_addr, prog_data, prog_we, busy, load_done, load_err, frame_err};
        req = {e_mode[c], e_addr[c], e_data[c], e_we[c], e_busy[c], e_done[c], e_err[c], e_ferr[c]};
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL outputs cycle %0d: got %b, expected %b (mode,addr,data,we,busy,done,err,ferr)",
                     c, act, req);
        end
        if (prog_we === 1'b1) begin
            n_we++;
            if (first_we < 0) first_we = c;
            $display("cycle %0d: write addr=%0d data=%02h", c, prog_addr, prog_data);
        end
        if (load_done === 1'b1) begin
            n_done++;
            $display("cycle %0d: load_done", c);
        end
        if (load_err === 1'b1) begin
            n_err++;
            err_q.push_back(c);
            $display("cycle %0d: load_err", c);
        end
        if (frame_err === 1'b1) begin
            n_ferr++;
            $display("cycle %0d: frame_err", c);
        end
    endtask

    always @(negedge fastClk) if (checking) do_check(cur);

    initial begin
        for (int c = 0; c < N; c++) begin
            rx_wave[c] = 1'b1; rst_wave[c] = (c >= 4);
            e_mode[c] = 0; e_we[c] = 0; e_busy[c] = 0; e_done[c] = 0;
            e_err[c] = 0; e_ferr[c] = 0; e_addr[c] = '0; e_data[c] = '0;
        end
        sess = 1'b0; cnt = 0; last_v = 0; sum = 8'h00;
        pc = 6;
        // full load of 00..0F
        plan_frame(SYNC, 1'b1);
        t1_first = pc;
        for (int i = 0; i < 16; i++) plan_frame(8'(i), 1'b1);
        plan_idle(20);
        // non-sync bytes while idle
        plan_frame(8'h3C, 1'b1);
        plan_frame(8'h11, 1'b1);
        plan_idle(10);
        // framing error after 5 data bytes
        plan_frame(SYNC, 1'b1);
        for (int i = 0; i < 5; i++) plan_frame(8'(8'h20 + i), 1'b1);
        plan_frame(8'h55, 1'b0);
        plan_idle(20);
        // timeout after 2 data bytes (the second is the sync value as data)
        plan_frame(SYNC, 1'b1);
        plan_frame(8'hAA, 1'b1);
        t4_last = pc;
        plan_frame(SYNC, 1'b1);
        plan_idle(80);
        // reset mid-byte, then a fresh complete load
        plan_frame(SYNC, 1'b1);
        for (int i = 0; i < 8; i++) plan_frame(8'(8'h80 + i), 1'b1);
        plan_cut_reset(8'h00, 15);
        plan_idle(10);
        plan_frame(SYNC, 1'b1);
        for (int i = 0; i < 16; i++) plan_frame(8'(8'h30 + 7 * i), 1'b1);
        plan_idle(20);
`ifdef PROG_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            plan_frame(SYNC, 1'b1);
            for (int i = 0; i < 16; i++) plan_frame(8'h01, 1'b1);
            plan_frame((k == 0) ? 8'h10 : 8'h11, 1'b1);
            plan_idle(20);
        end
`endif
        model_timeout(N);
        plan_len = pc;
        if (plan_len >= N) begin
            $display("FAIL plan length: got %0d, expected below %0d", plan_len, N);
            $fatal(1, "plan overflow");
        end

        for (int c = 0; c < plan_len; c++) begin
            @(posedge fastClk);
            #1;
            cur = c;
            rx  = rx_wave[c];
            rst = rst_wave[c];
            if (c == 1) checking = 1'b1;
        end
        @(negedge fastClk);
        #1;
        checking = 1'b0;

        model_we = 0;
        for (int c = 0; c < N; c++) if (e_we[c]) model_we++;
        check("model write count", model_we, N_WE);
        check("write pulses", n_we, N_WE);
        check("load_done pulses", n_done, N_DONE);
        check("load_err pulses", n_err, N_ERR);
        check("frame_err pulses", n_ferr, 1);
        check("first write latency", first_we - t1_first, 42);
        check("timeout latency", (err_q.size() >= 2) ? err_q[1] - t4_last : -1, 105);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
